trace_capture_unit: RTL and testbench

TRACE_CAPTURE_UNIT -- requirements
Module: trace_capture_unit

---
 rtl/trace_pkg.sv | 25 ++
 rtl/trace_fifo.sv | 67 ++++++
 rtl/trace_capture_unit.sv | 157 +++++++++++++++
 tb/tb_trace_capture_unit.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared types and constants for the trace capture unit.
// The writeback fields of the entry exist only when TRACE_WB_EN is defined.
package trace_pkg;

    localparam int DROP_W = 16;
    localparam int CYC_W  = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } trace_state_e;

    // Fixed-width part of an entry; the XLEN-wide PC (and writeback data)
    // are packed around it by the top, since the package cannot see XLEN.
    typedef struct packed {
        logic [31:0]      instr;
        logic [CYC_W-1:0] cycle;
`ifdef TRACE_WB_EN
        logic [4:0]       wb_addr;
`endif
    } trace_meta_t;

endpackage

// File: rtl/trace_fifo.sv
// Trace entry FIFO with a registered head: a push becomes visible on
// valid_o one cycle later, and a push into a full FIFO succeeds when a pop happens in the same cycle.
module trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic             full_o,
    output logic             empty_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rdPtr;
    logic [AW-1:0]    wrPtr;
    logic [AW:0]      count;
    logic             pop;
    logic             wrEn;
    logic [AW:0]      afterPop;
    logic [AW:0]      nextCount;
    logic [AW-1:0]    rdNext;

    assign full_o    = (count == FULL_CNT);
    assign empty_o   = (count == '0);
    assign pop       = valid_o && ready_i;
    assign wrEn      = push_i && (!full_o || pop);
    assign afterPop  = count - {{AW{1'b0}}, pop};
    assign nextCount = afterPop + {{AW{1'b0}}, wrEn};
    assign rdNext    = rdPtr + {{(AW-1){1'b0}}, pop};

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (wrEn) begin
            mem[wrPtr] <= data_i;
        end
    end

    // The head register takes the incoming entry when nothing older remains.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rdPtr   <= '0;
            wrPtr   <= '0;
            count   <= '0;
            valid_o <= 1'b0;
            data_o  <= '0;
        end else begin
            if (wrEn) begin
                wrPtr <= wrPtr + AW'(1);
            end
            rdPtr   <= rdNext;
            count   <= nextCount;
            valid_o <= (nextCount != '0);
            if (nextCount != '0) begin
                data_o <= (afterPop == '0) ? data_i : mem[rdNext];
            end
        end
    end

endmodule

// File: rtl/trace_capture_unit.sv
// Retirement trace capture: records retiring instructions into a FIFO until a run of zero instructions halts capture.
// Optional TRACE_WB_EN adds register writeback fields to each entry.
module trace_capture_unit
    import trace_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter int              DEPTH      = 16,
    parameter int              HALT_ZEROS = 1,
    parameter logic [XLEN-1:0] PC_OFFSET  = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              valid_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic [31:0]       instr_i,
`ifdef TRACE_WB_EN
    input  logic              wb_we_i,
    input  logic [4:0]        wb_addr_i,
    input  logic [XLEN-1:0]   wb_data_i,
    output logic [4:0]        out_wb_addr_o,
    output logic [XLEN-1:0]   out_wb_data_o,
`endif
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [XLEN-1:0]   out_pc_o,
    output logic [31:0]       out_instr_o,
    output logic [31:0]       out_cycle_o,
    output logic              done_o,
    output logic              overflow_o,
    output logic [DROP_W-1:0] drop_cnt_o
);

    localparam int META_W = $bits(trace_meta_t);
`ifdef TRACE_WB_EN
    localparam int ENTRY_W = XLEN + META_W + XLEN;
`else
    localparam int ENTRY_W = XLEN + META_W;
`endif

    trace_state_e     state;
    logic [CYC_W-1:0] cycleCnt;
    logic [3:0]       zeroRun;
    trace_meta_t      metaIn;
    trace_meta_t      headMeta;
    logic [ENTRY_W-1:0] entryIn;
    logic [ENTRY_W-1:0] headEntry;
    logic             pushReq;
    logic             pop;
    logic             drop;
    logic             isZero;
    logic             haltHit;
    logic             fifoFull;
    logic             fifoEmpty;

    assign pushReq = (state == RUN) && valid_i;
    assign pop     = out_valid_o && out_ready_i;
    assign drop    = pushReq && fifoFull && !pop;
    assign isZero  = (instr_i == 32'd0);
    assign haltHit = pushReq && isZero && (zeroRun == 4'(HALT_ZEROS - 1));

    always_comb begin
        metaIn       = '0;
        metaIn.instr = instr_i;
        metaIn.cycle = cycleCnt;
`ifdef TRACE_WB_EN
        metaIn.wb_addr = wb_we_i ? wb_addr_i : 5'd0;
`endif
    end

`ifdef TRACE_WB_EN
    assign entryIn       = {pc_i + PC_OFFSET, metaIn, wb_data_i};
    assign out_wb_data_o = headEntry[XLEN-1:0];
    assign out_wb_addr_o = headMeta.wb_addr;
`else
    assign entryIn = {pc_i + PC_OFFSET, metaIn};
`endif

    assign out_pc_o    = headEntry[ENTRY_W-1 -: XLEN];
    assign headMeta    = headEntry[ENTRY_W-XLEN-1 -: META_W];
    assign out_instr_o = headMeta.instr;
    assign out_cycle_o = headMeta.cycle;

    trace_fifo #(
        .WIDTH(ENTRY_W),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .push_i (pushReq),
        .data_i (entryIn),
        .ready_i(out_ready_i),
        .full_o (fifoFull),
        .empty_o(fifoEmpty),
        .valid_o(out_valid_o),
        .data_o (headEntry)
    );

    // A dropped terminating zero still counts toward halt, so the zero run
    // is tracked from pushReq rather than from the accepted push.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= IDLE;
            cycleCnt   <= '0;
            zeroRun    <= '0;
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
            done_o     <= 1'b0;
        end else begin
            if (drop) begin
                overflow_o <= 1'b1;
                if (drop_cnt_o != '1) begin
                    drop_cnt_o <= drop_cnt_o + DROP_W'(1);
                end
            end
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state    <= RUN;
                        cycleCnt <= '0;
                        zeroRun  <= '0;
                    end
                end
                RUN: begin
                    cycleCnt <= cycleCnt + CYC_W'(1);
                    if (valid_i) begin
                        if (haltHit) begin
                            state   <= DRAIN;
                            zeroRun <= '0;
                        end else if (isZero) begin
                            zeroRun <= zeroRun + 4'd1;
                        end else begin
                            zeroRun <= '0;
                        end
                    end
                end
                DRAIN: begin
                    if (fifoEmpty) begin
                        state  <= DONE;
                        done_o <= 1'b1;
                    end
                end
                DONE: begin
                    if (!start_i) begin
                        state  <= IDLE;
                        done_o <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    done_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trace_capture_unit.sv
// Scoreboard bench for trace_capture_unit: two instances with different
// parameters, a spec-level reference model and a decoupled output monitor.
module tb_trace_capture_unit;

    logic        clk = 1'b0;
    logic        rstN;
    logic        start    [2];
    logic        valid    [2];
    logic [31:0] pc       [2];
    logic [31:0] instr    [2];
    logic        outReady [2];
    logic        outValid [2];
    logic [31:0] outPc    [2];
    logic [31:0] outInstr [2];
    logic [31:0] outCycle [2];
    logic        done     [2];
    logic        overflow [2];
    logic [15:0] dropCnt  [2];
`ifdef TRACE_WB_EN
    logic        wbWe     [2];
    logic [4:0]  wbAddr   [2];
    logic [31:0] wbData   [2];
    logic [4:0]  outWbAddr[2];
    logic [31:0] outWbData[2];
`endif

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : gDut
        trace_capture_unit #(
            .XLEN      (32),
            .DEPTH     (g == 0 ? 16 : 4),
            .HALT_ZEROS(g == 0 ? 1 : 2),
            .PC_OFFSET (g == 0 ? 32'd0 : 32'd65556)
        ) dut (
            .clk_i        (clk),
            .rst_i        (rstN),
            .start_i      (start[g]),
            .valid_i      (valid[g]),
            .pc_i         (pc[g]),
            .instr_i      (instr[g]),
`ifdef TRACE_WB_EN
            .wb_we_i      (wbWe[g]),
            .wb_addr_i    (wbAddr[g]),
            .wb_data_i    (wbData[g]),
            .out_wb_addr_o(outWbAddr[g]),
            .out_wb_data_o(outWbData[g]),
`endif
            .out_valid_o  (outValid[g]),
            .out_ready_i  (outReady[g]),
            .out_pc_o     (outPc[g]),
            .out_instr_o  (outInstr[g]),
            .out_cycle_o  (outCycle[g]),
            .done_o       (done[g]),
            .overflow_o   (overflow[g]),
            .drop_cnt_o   (dropCnt[g])
        );
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] cyc;
    } exp_t;

    exp_t        expQ[$];
    int          total = 0;
    int          bad = 0;
    int          sel = 0;
    int          mOcc, mPhase, mZeros, mDrop;
    logic [31:0] mCyc;
    bit          mOvf;

    function automatic int depthOf(int d);
        return (d == 0) ? 16 : 4;
    endfunction

    function automatic int haltOf(int d);
        return (d == 0) ? 1 : 2;
    endfunction

    function automatic logic [31:0] offOf(int d);
        return (d == 0) ? 32'd0 : 32'd65556;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h (dut %0d, t=%0t)", name, act, exp, sel, $time);
        end
    endtask

    task automatic modelReset();
        mOcc = 0; mPhase = 0; mZeros = 0; mDrop = 0; mCyc = '0; mOvf = 1'b0;
        expQ.delete();
    endtask

    // One clock cycle: drive, check status against the model, then advance the model.
    task automatic applyStimulus(input bit s, input bit v, input logic [31:0] p,
                                 input logic [31:0] ins, input bit rdy);
        bit doPop;
        bit doPush;
        exp_t e;
        start[sel] = s; valid[sel] = v; pc[sel] = p; instr[sel] = ins; outReady[sel] = rdy;
        @(negedge clk);
        checkOutput("out_valid", outValid[sel], 32'(mOcc > 0));
        checkOutput("done", done[sel], 32'(mPhase == 3));
        checkOutput("overflow", overflow[sel], 32'(mOvf));
        checkOutput("drop_cnt", dropCnt[sel], mDrop);
        #1;
        doPop  = (mOcc > 0) && rdy;
        doPush = 1'b0;
        case (mPhase)
            0: if (s) begin mPhase = 1; mCyc = '0; mZeros = 0; end
            1: begin
                if (v) begin
                    e.pc = p + offOf(sel); e.instr = ins; e.cyc = mCyc;
                    if (mOcc < depthOf(sel) || doPop) begin
                        expQ.push_back(e);
                        doPush = 1'b1;
                    end else begin
                        mOvf = 1'b1;
                        if (mDrop < 65535) mDrop++;
                    end
                    if (ins == 32'd0) begin
                        mZeros++;
                        if (mZeros == haltOf(sel)) begin mPhase = 2; mZeros = 0; end
                    end else begin
                        mZeros = 0;
                    end
                end
                mCyc = mCyc + 32'd1;
            end
            2: if (mOcc == 0) mPhase = 3;
            default: if (!s) mPhase = 0;
        endcase
        mOcc = mOcc + int'(doPush) - int'(doPop);
        @(posedge clk);
        #1;
    endtask

    // Drain with ready held high until the model reaches DONE, then return to IDLE.
    task automatic finishRun();
        int n = 0;
        while (mPhase != 3 && n < 40) begin
            applyStimulus(1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
            n++;
        end
        checkOutput("done_reached", done[sel], 32'd1);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rstN && outValid[sel] && outReady[sel]) begin
            if (expQ.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_entry actual pc=%0h required=none (dut %0d)", outPc[sel], sel);
            end else begin
                e = expQ.pop_front();
                checkOutput("entry_pc", outPc[sel], e.pc);
                checkOutput("entry_instr", outInstr[sel], e.instr);
                checkOutput("entry_cycle", outCycle[sel], e.cyc);
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            start[d] = 0; valid[d] = 0; pc[d] = 0; instr[d] = 0; outReady[d] = 0;
`ifdef TRACE_WB_EN
            wbWe[d] = 0; wbAddr[d] = 0; wbData[d] = 0;
`endif
        end
        rstN = 1'b0;
        modelReset();
        #2;
        for (int d = 0; d < 2; d++) begin
            sel = d;
            checkOutput("reset_valid", outValid[d], 32'd0);
            checkOutput("reset_pc", outPc[d], 32'd0);
            checkOutput("reset_cycle", outCycle[d], 32'd0);
            checkOutput("reset_done", done[d], 32'd0);
            checkOutput("reset_drop", dropCnt[d], 32'd0);
        end
        @(posedge clk); #1;
        rstN = 1'b1;

        $display("[TB] basic capture on default instance");
        sel = 0;
        applyStimulus(1'b1, 1'b1, 32'h100, 32'h13, 1'b1);
        applyStimulus(1'b1, 1'b1, 32'd0, 32'h00500093, 1'b1);
        applyStimulus(1'b1, 1'b1, 32'd4, 32'h00108133, 1'b1);
        applyStimulus(1'b1, 1'b1, 32'd8, 32'h00000000, 1'b1);
        finishRun();

        $display("[TB] offset, overflow and full-with-pop on small instance");
        sel = 1;
        applyStimulus(1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
        applyStimulus(1'b1, 1'b1, 32'd4, 32'h13, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b1, 32'(16 + 4 * i), 32'h00100093 + 32'(i), 1'b0);
        end
        checkOutput("overflow_set", overflow[1], 32'd1);
        checkOutput("drop_two", dropCnt[1], 32'd2);
        applyStimulus(1'b1, 1'b1, 32'h40, 32'h00200113, 1'b1);
        checkOutput("drop_after_full_pop", dropCnt[1], 32'd2);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
        end

        $display("[TB] two-zero halt sequence");
        applyStimulus(1'b1, 1'b1, 32'h80, 32'h0, 1'b1);
        applyStimulus(1'b1, 1'b1, 32'h84, 32'h00300193, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b1);
        applyStimulus(1'b1, 1'b1, 32'h88, 32'h0, 1'b1);
        applyStimulus(1'b1, 1'b1, 32'h8c, 32'h0, 1'b1);
        finishRun();

        $display("[TB] reset during drain");
        applyStimulus(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h200, 32'h13, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h204, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h208, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("rst_valid", outValid[1], 32'd0);
        checkOutput("rst_pc", outPc[1], 32'd0);
        checkOutput("rst_overflow", overflow[1], 32'd0);
        checkOutput("rst_drop", dropCnt[1], 32'd0);
        checkOutput("rst_done", done[1], 32'd0);
        modelReset();
        @(posedge clk); #1;
        rstN = 1'b1;
        applyStimulus(1'b0, 1'b1, 32'h300, 32'h13, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'h304, 32'h13, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

        $display("[TB] randomized runs");
        for (int d = 0; d < 2; d++) begin
            sel = d;
            applyStimulus(1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
            for (int n = 0; n < 300 && mPhase == 1; n++) begin
                applyStimulus(1'b1, 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC,
                              ($urandom_range(0, 11) == 0) ? 32'd0 : ($urandom | 32'd1),
                              $urandom_range(0, 3) != 0);
            end
            for (int n = 0; n < 300 && mPhase == 1; n++) begin
                applyStimulus(1'b1, 1'b1, 32'h1000, 32'd0, 1'b1);
            end
            finishRun();
        end

        $display("[TB] test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
